// File: rtl/arith4_engine_if.sv
// arith4_engine_if
//   Bundles the bus-side signals of the four-operand compute core.
//   Signals:
//     iControl  4   [0]=start level, [3:1]=opcode
//     iA..iD    DW  operands
//     oResult   DW  result of the last completed operation
//     oStatus   2   [0]=busy, [1]=done
//   Modports:
//     master  drives control/operands, reads result/status (register slave side)
//     slave   the compute core itself
interface arith4_engine_if #(
  parameter int DW = 32
);
  logic [3:0]    iControl;
  logic [DW-1:0] iA;
  logic [DW-1:0] iB;
  logic [DW-1:0] iC;
  logic [DW-1:0] iD;
  logic [DW-1:0] oResult;
  logic [1:0]    oStatus;

  modport master (
    output iControl, iA, iB, iC, iD,
    input  oResult, oStatus
  );

  modport slave (
    input  iControl, iA, iB, iC, iD,
    output oResult, oStatus
  );
endinterface

// File: rtl/arith4_engine.sv
// arith4_engine
//   Compute core behind the four-operand register slave. A rising edge on
//   the start bit launches one operation on operands A..D: add-type ops
//   finish in one clock, multiplies run a radix-2 shift-add loop, one
//   multiplier bit per clock (DW clocks for A*B, 2*DW for A*B+C*D).
//   Opcodes: 000 A+B+C+D, 001 A+B-C-D, 010 A*B, 011 A*B+C*D,
//            100 unsigned max, others -> 0. All results are mod 2^DW.
//   Ports:
//     iClk      clock, posedge
//     iReset_n  asynchronous active-low reset
//     bus       slave modport of arith4_engine_if (control, operands,
//               registered result and {done, busy} status)
module arith4_engine #(
  parameter int DW = 32
) (
  input  logic            iClk,
  input  logic            iReset_n,
  arith4_engine_if.slave  bus
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    MUL1,
    MUL2,
    DONE
  } state_t;

  state_t        state_q;
  logic          start_q;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q, c_q, d_q;
  logic [DW-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] result_q;
  logic          busy_q, done_q;

  logic          startPulse;
  logic [DW-1:0] acc_d;
  logic [DW-1:0] addResult_d;
  logic [DW-1:0] maxAB, maxCD;

  // Start is level-driven from the bus; only its rising edge launches an op.
  assign startPulse = bus.iControl[0] & ~start_q;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle add-type results from the latched operands.
  always_comb begin
    maxAB       = (a_q > b_q) ? a_q : b_q;
    maxCD       = (c_q > d_q) ? c_q : d_q;
    addResult_d = '0;
    case (op_q)
      3'b000:  addResult_d = a_q + b_q + c_q + d_q;
      3'b001:  addResult_d = a_q + b_q - c_q - d_q;
      3'b100:  addResult_d = (maxAB > maxCD) ? maxAB : maxCD;
      default: addResult_d = '0;
    endcase
  end

  // Control FSM and datapath. Starts are only accepted in IDLE/DONE, so a
  // re-armed start during a running op is dropped (start_q still tracks it).
  // For A*B+C*D the accumulator is kept across the two multiply passes.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q <= bus.iControl[0];
      case (state_q)
        IDLE, DONE: begin
          if (startPulse) begin
            op_q     <= bus.iControl[3:1];
            a_q      <= bus.iA;
            b_q      <= bus.iB;
            c_q      <= bus.iC;
            d_q      <= bus.iD;
            mcand_q  <= bus.iA;
            mplier_q <= bus.iB;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            if (bus.iControl[3:1] == 3'b010 || bus.iControl[3:1] == 3'b011)
              state_q <= MUL1;
            else
              state_q <= ADD;
          end
        end
        ADD: begin
          result_q <= addResult_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        MUL1, MUL2: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            if (state_q == MUL1 && op_q == 3'b011) begin
              mcand_q  <= c_q;
              mplier_q <= d_q;
              cnt_q    <= '0;
              state_q  <= MUL2;
            end else begin
              result_q <= acc_d;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oResult = result_q;
  assign bus.oStatus = {done_q, busy_q};

endmodule

// File: tb/tb_arith4_engine.sv
// tb_arith4_engine
//   Self-checking bench for arith4_engine: directed cases plus randomized
//   operations compared against a plain-arithmetic reference model, with
//   latency, status, hold-in-DONE and mid-op reset checks.
module tb_arith4_engine;

  localparam int DW = 32;

  logic iClk;
  logic iReset_n;
  int   checks;
  int   errors;
  logic [DW-1:0] lastResult;

  arith4_engine_if #(.DW(DW)) bus ();

  arith4_engine #(.DW(DW)) dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .bus      (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference result computed directly from the opcode meaning.
  function automatic logic [DW-1:0] refResult(input logic [2:0] op,
                                               input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] vals [4];
    logic [DW-1:0] m;
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    case (op)
      3'b000:  return a + b + c + d;
      3'b001:  return a + b - c - d;
      3'b010:  return a * b;
      3'b011:  return a * b + c * d;
      3'b100: begin
        m = 0;
        foreach (vals[i]) if (vals[i] > m) m = vals[i];
        return m;
      end
      default: return '0;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op);
    if (op == 3'b010) return DW;
    if (op == 3'b011) return 2 * DW;
    return 1;
  endfunction

  // Shared comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one operation end to end: launch, busy/hold checks, latency,
  // result, and that done is held while start stays high.
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] a, b, c, d,
                               input bit toggleStart);
    logic [DW-1:0] expected;
    int            n;
    expected = refResult(op, a, b, c, d);
    @(negedge iClk);
    bus.iControl = {op, 1'b0};
    @(negedge iClk);
    bus.iA = a; bus.iB = b; bus.iC = c; bus.iD = d;
    bus.iControl = {op, 1'b1};
    @(posedge iClk);
    #1;
    checkOutput("busyAfterStart", DW'(bus.oStatus), DW'(2'b01));
    checkOutput("resultHeldBusy", bus.oResult, lastResult);
    bus.iA = $urandom; bus.iB = $urandom; bus.iC = $urandom; bus.iD = $urandom;
    bus.iControl[3:1] = 3'($urandom);
    n = 0;
    do begin
      @(posedge iClk);
      #1;
      n++;
      if (toggleStart && n == 10) bus.iControl[0] = 1'b0;
      if (toggleStart && n == 11) bus.iControl[0] = 1'b1;
    end while (bus.oStatus[1] !== 1'b1 && n < 300);
    checkOutput("latency", DW'(n), DW'(refLatency(op)));
    checkOutput("result", bus.oResult, expected);
    checkOutput("statusDone", DW'(bus.oStatus), DW'(2'b10));
    lastResult = expected;
    repeat (2) @(posedge iClk);
    #1;
    checkOutput("doneHeld", DW'(bus.oStatus), DW'(2'b10));
    checkOutput("resultHeld", bus.oResult, expected);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    lastResult   = '0;
    iReset_n     = 1'b0;
    bus.iControl = 4'b0000;
    bus.iA = '0; bus.iB = '0; bus.iC = '0; bus.iD = '0;
    #12;
    checkOutput("resetResult", bus.oResult, '0);
    checkOutput("resetStatus", DW'(bus.oStatus), '0);
    @(negedge iClk);
    iReset_n = 1'b1;

    applyStimulus(3'b000, 1, 2, 3, 4, 1'b0);
    applyStimulus(3'b001, 5, 1, 7, 0, 1'b0);
    applyStimulus(3'b010, 1234, 5678, 0, 0, 1'b0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    applyStimulus(3'b011, 3, 4, 5, 6, 1'b1);
    applyStimulus(3'b100, 9, 32'h8000_0000, 7, 1, 1'b0);
    applyStimulus(3'b101, 11, 22, 33, 44, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a long multiply-accumulate.
    @(negedge iClk);
    bus.iControl = 4'b0110;
    @(negedge iClk);
    bus.iA = 3; bus.iB = 4; bus.iC = 5; bus.iD = 6;
    bus.iControl = 4'b0111;
    repeat (20) @(posedge iClk);
    #1;
    checkOutput("busyBeforeReset", DW'(bus.oStatus), DW'(2'b01));
    #2;
    iReset_n = 1'b0;
    #1;
    checkOutput("abortResult", bus.oResult, '0);
    checkOutput("abortStatus", DW'(bus.oStatus), '0);
    lastResult   = '0;
    bus.iControl = 4'b0110;
    @(negedge iClk);
    iReset_n = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("idleAfterReset", DW'(bus.oStatus), '0);
    checkOutput("resultAfterReset", bus.oResult, '0);
    applyStimulus(3'b011, 3, 4, 5, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
